// File: rtl/seq_alu.sv
// Sequential N-bit ALU: logic/add/compare in one cycle, iterative MUL/DIV; latency 1 (N+1 for MUL/DIV).
// Valid/ready on both sides: in_ready only in IDLE, result and flags held in DONE until out_ready.
module seq_alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ALUresult,
    output logic         Zero,
    output logic         Negative,
    output logic         Overflow,
    output logic         CarryOut,
    output logic         DivZero
);
    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                           OP_XOR  = 4'b0011, OP_NOR  = 4'b0100, OP_SLTU = 4'b0101,
                           OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_MUL  = 4'b1000,
                           OP_MULH = 4'b1001, OP_DIVU = 4'b1010, OP_REMU = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    res_q, res_d;
    logic            zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic            cout_q, cout_d, dz_q, dz_d;

    logic            is_sub, ovf_add, ovf_sub;
    logic [N:0]      sum;
    logic [N:0]      mul_add, div_sh, div_tr;
    logic [2*N-1:0]  mul_nxt;
    logic            div_ge, last_iter;
    logic [N-1:0]    rem_nxt, quo_nxt;
    logic            fin, f_ovf, f_cout, f_dz, f_undef;
    logic [N-1:0]    f_res;

    // SUB/SLT/SLTU share the adder as A + ~B + 1; the N+1th bit is the carry.
    always_comb begin
        is_sub  = (ALUctrl == OP_SUB) || (ALUctrl == OP_SLT) || (ALUctrl == OP_SLTU);
        sum     = {1'b0, A} + {1'b0, (is_sub ? ~B : B)} + {{N{1'b0}}, is_sub};
        ovf_add = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
        ovf_sub = (A[N-1] != B[N-1]) && (sum[N-1] != A[N-1]);
    end

    // acc holds {partial product, remaining multiplier bits} for MUL, the quotient shifter for DIV.
    always_comb begin
        mul_add   = acc_q[0] ? ({1'b0, acc_q[2*N-1:N]} + {1'b0, a_q}) : {1'b0, acc_q[2*N-1:N]};
        mul_nxt   = {mul_add, acc_q[N-1:1]};
        div_sh    = {rem_q, acc_q[N-1]};
        div_tr    = div_sh - {1'b0, b_q};
        div_ge    = !div_tr[N];
        rem_nxt   = div_ge ? div_tr[N-1:0] : div_sh[N-1:0];
        quo_nxt   = {acc_q[N-2:0], div_ge};
        last_iter = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        dz_d    = dz_q;
        fin     = 1'b0;
        f_res   = '0;
        f_ovf   = 1'b0;
        f_cout  = 1'b0;
        f_dz    = 1'b0;
        f_undef = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = ALUctrl;
                    cnt_d   = '0;
                    fin     = 1'b1;
                    state_d = S_DONE;
                    case (ALUctrl)
                        OP_AND:  f_res = A & B;
                        OP_OR:   f_res = A | B;
                        OP_XOR:  f_res = A ^ B;
                        OP_NOR:  f_res = ~(A | B);
                        OP_ADD: begin
                            f_res  = sum[N-1:0];
                            f_ovf  = ovf_add;
                            f_cout = sum[N];
                        end
                        OP_SUB: begin
                            f_res  = sum[N-1:0];
                            f_ovf  = ovf_sub;
                            f_cout = sum[N];
                        end
                        OP_SLT: begin
                            f_res = {{(N-1){1'b0}}, sum[N-1] ^ ovf_sub};
                            f_ovf = ovf_sub;
                        end
                        OP_SLTU: f_res = {{(N-1){1'b0}}, ~sum[N]};
                        OP_MUL, OP_MULH: begin
                            fin     = 1'b0;
                            acc_d   = {{N{1'b0}}, B};
                            state_d = S_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            if (B == '0) begin
                                f_res = (ALUctrl == OP_DIVU) ? '1 : A;
                                f_dz  = 1'b1;
                            end else begin
                                fin     = 1'b0;
                                acc_d   = {{N{1'b0}}, A};
                                rem_d   = '0;
                                state_d = S_DIV;
                            end
                        end
                        default: f_undef = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    fin     = 1'b1;
                    f_res   = (op_q == OP_MULH) ? mul_nxt[2*N-1:N] : mul_nxt[N-1:0];
                    f_ovf   = |mul_nxt[2*N-1:N];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = {{N{1'b0}}, quo_nxt};
                rem_d = rem_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    fin     = 1'b1;
                    f_res   = (op_q == OP_DIVU) ? quo_nxt : rem_nxt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            res_d  = f_res;
            zero_d = (f_res == '0) && !f_undef;
            neg_d  = f_res[N-1];
            ovf_d  = f_ovf;
            cout_d = f_cout;
            dz_d   = f_dz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUresult = res_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = cout_q;
    assign DivZero   = dz_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed cases plus randomized ops against an arithmetic reference model.
module tb_seq_alu;
    localparam int N    = 8;
    localparam int SMAX = 2 ** (N - 1) - 1;
    localparam int SMIN = -(2 ** (N - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   ALUctrl = '0;
    logic         in_ready, out_valid, Zero, Negative, Overflow, CarryOut, DivZero;
    logic [N-1:0] ALUresult;

    seq_alu #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUctrl(ALUctrl), .out_valid(out_valid), .out_ready(out_ready),
        .ALUresult(ALUresult), .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
        .CarryOut(CarryOut), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    // flg = {Zero, Negative, Overflow, CarryOut, DivZero}
    typedef struct {
        logic [N-1:0] res;
        logic [4:0]   flg;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] res, input logic [4:0] flg, input int lat);
        exp_t e;
        e.res = res; e.flg = flg; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t           e;
        int             sa, sbv, sd;
        logic [2*N-1:0] p;
        logic           v, c, dz, undef;
        e.res = '0; e.lat = 1; e.acc_cyc = 0;
        v = 1'b0; c = 1'b0; dz = 1'b0; undef = 1'b0;
        sa  = $signed(a);
        sbv = $signed(b);
        p   = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd3: e.res = a ^ b;
            4'd4: e.res = ~(a | b);
            4'd2: begin
                e.res = a + b;
                c  = (int'(a) + int'(b)) > ((1 << N) - 1);
                sd = sa + sbv;
                v  = (sd > SMAX) || (sd < SMIN);
            end
            4'd6: begin
                e.res = a - b;
                c  = (a >= b);
                sd = sa - sbv;
                v  = (sd > SMAX) || (sd < SMIN);
            end
            4'd7: begin
                e.res = {{(N-1){1'b0}}, (sa < sbv)};
                sd = sa - sbv;
                v  = (sd > SMAX) || (sd < SMIN);
            end
            4'd5: e.res = {{(N-1){1'b0}}, (a < b)};
            4'd8, 4'd9: begin
                e.res = (op == 4'd8) ? p[N-1:0] : p[2*N-1:N];
                v     = (p[2*N-1:N] != '0);
                e.lat = N + 1;
            end
            4'd10, 4'd11: begin
                if (b == '0) begin
                    e.res = (op == 4'd10) ? {N{1'b1}} : a;
                    dz    = 1'b1;
                end else begin
                    e.res = (op == 4'd10) ? (a / b) : (a % b);
                    e.lat = N + 1;
                end
            end
            default: undef = 1'b1;
        endcase
        e.flg = {(e.res == '0) && !undef, e.res[N-1], v, c, dz};
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got result 0x%0h with no op outstanding", ALUresult);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(ALUresult), 32'(mon_e.res));
                check("flags_ZNVCD", 32'({Zero, Negative, Overflow, CarryOut, DivZero}), 32'(mon_e.flg));
                check("latency", 32'(cyc - mon_e.acc_cyc + 1), 32'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0, expected 1");
            return;
        end
        in_valid = 1'b1; A = a; B = b; ALUctrl = op;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); ALUctrl = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d ops outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        logic [3:0]   op;
        logic [N-1:0] a, b;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(ALUresult), 32'd0);
        check("rst_flags", 32'({Zero, Negative, Overflow, CarryOut, DivZero}), 32'd0);
        rst_n = 1'b1;

        issue(4'b0010, 8'h7F, 8'h01, mk(8'h80, 5'b01100, 1));
        issue(4'b0111, 8'hF9, 8'h06, mk(8'h01, 5'b00000, 1));
        issue(4'b0101, 8'hF9, 8'h06, mk(8'h00, 5'b10000, 1));
        issue(4'b0110, 8'h05, 8'h05, mk(8'h00, 5'b10010, 1));
        issue(4'b1000, 8'h10, 8'h20, mk(8'h00, 5'b10100, N + 1));
        issue(4'b1001, 8'h10, 8'h20, mk(8'h02, 5'b00100, N + 1));
        issue(4'b1010, 8'hC8, 8'h07, mk(8'h1C, 5'b00000, N + 1));
        issue(4'b1011, 8'hC8, 8'h07, mk(8'h04, 5'b00000, N + 1));
        issue(4'b1010, 8'h55, 8'h00, mk(8'hFF, 5'b01001, 1));
        issue(4'b1011, 8'h55, 8'h00, mk(8'h55, 5'b00001, 1));
        issue(4'b1100, 8'h00, 8'h00, mk(8'h00, 5'b00000, 1));
        drain();

        // Backpressure: result must hold and a pulsed in_valid must be ignored.
        rdy_mode = 1;
        issue(4'b0010, 8'h7F, 8'h01, mk(8'h80, 5'b01100, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_result", 32'(ALUresult), 32'h80);
            check("bp_flags", 32'({Zero, Negative, Overflow, CarryOut, DivZero}), 32'b01100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            if (i == 1) begin
                in_valid = 1'b1; A = 8'h11; B = 8'h22; ALUctrl = 4'b0001;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rdy_mode = 2;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; A = 8'h0F; B = 8'h0F; ALUctrl = 4'b1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", 32'(ALUresult), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        check("midrst_discarded", 32'(out_valid), 32'd0);
        issue(4'b0010, 8'h03, 8'h04, mk(8'h07, 5'b00000, 1));
        drain();

        rdy_mode = 0;
        for (int k = 0; k < 150; k++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       a = 8'h80;
                1:       a = 8'h7F;
                default: a = N'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = 8'h80;
                default: b = N'($urandom);
            endcase
            issue(op, a, b, model(op, a, b));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised N-bit sequential ALU; the next generation of the team's combinational ALU, sitting between the register-file read stage and writeback in the Ottobit datapath.
- Adds a 4-bit op code, correct signed and unsigned SLT, and XOR/NOR.
- Adds iterative unsigned multiply and divide.
- Registers the result and all flags behind a valid/ready handshake on both input and output.

Parameters:
- N, 8, operand/result width in bits; N >= 4.
- CW, $clog2(N+1) (localparam), iteration counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and op code are presented.
- in_ready  out  1  block accepts an op; high only in IDLE.
- A  in  N  operand A.
- B  in  N  operand B.
- ALUctrl  in  4  op select.
- out_valid  out  1  ALUresult and flags are valid.
- out_ready  in  1  consumer takes the result.
- ALUresult  out  N  registered result.
- Zero  out  1  ALUresult == 0.
- Negative  out  1  ALUresult[N-1].
- Overflow  out  1  signed overflow (ADD/SUB) or product does not fit (MUL).
- CarryOut  out  1  carry out of bit N-1 (ADD/SUB only).
- DivZero  out  1  divide or remainder with B == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all outputs 0 except in_ready=1.
  - Any in-flight op is discarded, with no partial result.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB (A+~B+1).
  - 0111 SLT signed: result = S[N-1]^Overflow, zero-extended.
  - 0101 SLTU: result = ~carry of A-B.
  - 1000 MUL: low N bits of A*B, unsigned.
  - 1001 MULH: high N bits.
  - 1010 DIVU: quotient.
  - 1011 REMU: remainder.
  - Undefined codes: result 0, all flags 0, single-cycle path.
- Flags:
  - Zero and Negative are derived from the final ALUresult for every op.
  - Overflow, ADD: A[N-1]==B[N-1] && S[N-1]!=A[N-1].
  - Overflow, SUB/SLT: A[N-1]!=B[N-1] && S[N-1]!=A[N-1].
  - Overflow, MUL/MULH: high half != 0.
  - Overflow is 0 for all other ops.
  - CarryOut is valid for ADD/SUB only, else 0; for SUB, 1 means no borrow.
  - DivZero is valid for DIVU/REMU only, else 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch A, B, ALUctrl.
  - Single-cycle op: compute and register the result, then go to DONE. out_valid is high the cycle after accept (latency 1).
  - MUL/MULH: go to MUL with cnt=0.
  - DIVU/REMU with B != 0: go to DIV with cnt=0.
  - DIVU/REMU with B==0: go straight to DONE with quotient all-ones, remainder=A, DivZero=1 (latency 1).
- MUL: shift-add, one multiplier bit per cycle, 2N-bit accumulator. After N iterations go to DONE. out_valid rises N+1 cycles after accept.
- DIV: restoring division, one quotient bit per cycle, N iterations, then DONE. Latency N+1.
- DONE:
  - out_valid=1; ALUresult and flags are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready: go to IDLE and drop out_valid next cycle. Peak throughput is one op per 2 cycles.
- Boundary rules:
  - in_valid while not in IDLE is not accepted; the source holds it.
  - Operand inputs changing during MUL/DIV have no effect, since they were latched.
  - out_ready while out_valid=0 is ignored.
  - Reset mid-MUL/DIV returns to IDLE immediately with in_ready=1.
- Width rules:
  - Internal adder is N+1 bits.
  - Multiplier accumulator is 2N bits.
  - Divider partial remainder is N+1 bits.
  - No truncation before flag computation.

Test Plan:
- ADD A=0x7F B=0x01 -> ALUresult=0x80, Overflow=1, Negative=1, CarryOut=0, Zero=0; out_valid 1 cycle after accept.
- SLT A=0xF9 (-7) B=0x06 -> 0x01. SLTU with the same operands -> 0x00. SUB A=0x05 B=0x05 -> 0x00, Zero=1, CarryOut=1.
- MUL A=0x10 B=0x20 -> 0x00, Zero=1, Overflow=1. MULH with the same operands -> 0x02, Overflow=1. out_valid exactly 9 cycles after accept.
- DIVU A=0xC8 B=0x07 -> 0x1C. REMU with the same operands -> 0x04. DIVU A=0x55 B=0x00 -> 0xFF, DivZero=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> ALUresult and flags stable, in_ready=0, a pulsed in_valid is not accepted. Raise out_ready -> IDLE next cycle.
- Reset: rst_n low during MUL iteration 3 -> out_valid=0 and in_ready=1 asynchronously. Release, then ADD 0x03+0x04 -> 0x07.
